// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, MIPS opcode/funct
// fields, datapath select codes and the decoded instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_REG    = 2'b11;

  localparam logic [1:0] WA_RT = 2'b00;
  localparam logic [1:0] WA_RD = 2'b01;
  localparam logic [1:0] WA_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_SUBU = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  typedef enum logic [3:0] {
    IC_ILLEGAL,
    IC_ADDU,
    IC_SUBU,
    IC_ORI,
    IC_LUI,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_J,
    IC_JR,
    IC_JAL
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct to instruction-class decoder.
// jal is recognised only when MC_CTRL_JAL_EN is defined; otherwise it is illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  always_comb begin
    iclass = IC_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = IC_ADDU;
          FN_SUBU: iclass = IC_SUBU;
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_J:   iclass = IC_J;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: iclass = IC_JAL;
`else
      OP_JAL: iclass = IC_ILLEGAL;
`endif
      OP_BEQ: iclass = IC_BEQ;
      OP_ORI: iclass = IC_ORI;
      OP_LUI: iclass = IC_LUI;
      OP_LW:  iclass = IC_LW;
      OP_SW:  iclass = IC_SW;
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB FSM plus a
// retired-instruction counter. Optional jal support via MC_CTRL_JAL_EN.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic             rf_we,
  output logic [1:0]       rf_wa_sel,
  output logic [1:0]       rf_wd_sel,
  output logic [2:0]       alu_op,
  output logic             alu_src_b,
  output logic             ext_op,
  output logic             dm_we,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t  state_q;
  state_t  state_n;
  iclass_t iclass;
  logic    retire;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass)
  );

  assign state = state_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_n;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = S_FETCH;
    pc_we   = 1'b0;
    npc_sel = NPC_SEQ;
    ir_we   = 1'b0;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          IC_J:       begin pc_we = 1'b1; npc_sel = NPC_JUMP; end
          IC_JR:      begin pc_we = 1'b1; npc_sel = NPC_REG;  end
          IC_JAL:     begin pc_we = 1'b1; npc_sel = NPC_JUMP; rf_we = 1'b1; end
          IC_ILLEGAL: illegal = 1'b1;
          default:    state_n = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (iclass)
          IC_BEQ: begin
            pc_we   = zero;
            npc_sel = NPC_BRANCH;
          end
          IC_LW, IC_SW: state_n = S_MEM;
          default:      state_n = S_WB;
        endcase
      end
      S_MEM: begin
        if (iclass == IC_LW) state_n = S_WB;
        else if (iclass == IC_SW) dm_we = 1'b1;
      end
      S_WB: rf_we = 1'b1;
      default: ;
    endcase
    // Reset overrides any decode so no stray write escapes while held.
    if (reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      rf_we   = 1'b0;
      dm_we   = 1'b0;
      illegal = 1'b0;
    end
  end

  assign retire = (state_q != S_FETCH) && (state_n == S_FETCH) && !illegal;

  // Datapath controls depend only on the instruction, so they stay stable
  // across EXEC, MEM and WB.
  always_comb begin
    alu_op    = ALU_ADDU;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    rf_wa_sel = WA_RT;
    rf_wd_sel = WD_ALU;
    case (iclass)
      IC_ADDU: rf_wa_sel = WA_RD;
      IC_SUBU: begin alu_op = ALU_SUBU; rf_wa_sel = WA_RD; end
      IC_ORI:  begin alu_op = ALU_OR;   alu_src_b = 1'b1; end
      IC_LUI:  begin alu_op = ALU_LUI;  alu_src_b = 1'b1; end
      IC_LW:   begin alu_src_b = 1'b1;  ext_op = 1'b1; rf_wd_sel = WD_DM; end
      IC_SW:   begin alu_src_b = 1'b1;  ext_op = 1'b1; end
      IC_BEQ:  begin alu_op = ALU_SUBU; ext_op = 1'b1; end
      IC_JAL:  begin rf_wa_sel = WA_RA; rf_wd_sel = WD_PC; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl (CNT_W=4 to exercise counter wrap).
// jal expectations follow MC_CTRL_JAL_EN.
module tb_mc_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = 6'b0;
  logic [5:0]    funct = 6'b0;
  logic          zero = 1'b0;
  logic          pc_we, ir_we, rf_we, dm_we, alu_src_b, ext_op, illegal;
  logic [1:0]    npc_sel, rf_wa_sel, rf_wd_sel;
  logic [2:0]    alu_op, state;
  logic [CW-1:0] retired;

  int n_checks = 0;
  int n_fail = 0;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .pc_we     (pc_we),
    .npc_sel   (npc_sel),
    .ir_we     (ir_we),
    .rf_we     (rf_we),
    .rf_wa_sel (rf_wa_sel),
    .rf_wd_sel (rf_wd_sel),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .ext_op    (ext_op),
    .dm_we     (dm_we),
    .state     (state),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] wev();
    return {illegal, pc_we, ir_we, rf_we, dm_we};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Check state and {illegal,pc_we,ir_we,rf_we,dm_we} for this cycle, then advance.
  task automatic step(input string tag, input logic [2:0] s, input logic [4:0] we);
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".we"}, 32'(wev()), 32'(we));
    cyc();
  endtask

  task automatic load(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc();
    cyc();
    check("rst.state", 32'(state), 32'd0);
    check("rst.ret", 32'(retired), 32'd0);
    check("rst.we", 32'(wev()), 32'd0);
    reset = 1'b0;

    // addu: 0,1,2,4,0
    load(6'b000000, 6'b100001);
    step("addu.F", 3'd0, 5'b01100);
    step("addu.D", 3'd1, 5'b00000);
    check("addu.E.alu", 32'(alu_op), 32'd0);
    step("addu.E", 3'd2, 5'b00000);
    check("addu.W.wa", 32'(rf_wa_sel), 32'd1);
    check("addu.W.wd", 32'(rf_wd_sel), 32'd0);
    step("addu.W", 3'd4, 5'b00010);
    check("addu.ret", 32'(retired), 32'd1);

    // subu
    load(6'b000000, 6'b100011);
    step("subu.F", 3'd0, 5'b01100);
    step("subu.D", 3'd1, 5'b00000);
    check("subu.E.alu", 32'(alu_op), 32'd1);
    check("subu.E.srcb", 32'(alu_src_b), 32'd0);
    step("subu.E", 3'd2, 5'b00000);
    check("subu.W.wa", 32'(rf_wa_sel), 32'd1);
    step("subu.W", 3'd4, 5'b00010);

    // ori
    load(6'b001101, 6'b000000);
    step("ori.F", 3'd0, 5'b01100);
    step("ori.D", 3'd1, 5'b00000);
    check("ori.E.alu", 32'(alu_op), 32'd2);
    check("ori.E.srcb", 32'(alu_src_b), 32'd1);
    check("ori.E.ext", 32'(ext_op), 32'd0);
    step("ori.E", 3'd2, 5'b00000);
    check("ori.W.wa", 32'(rf_wa_sel), 32'd0);
    check("ori.W.wd", 32'(rf_wd_sel), 32'd0);
    step("ori.W", 3'd4, 5'b00010);

    // lui
    load(6'b001111, 6'b000000);
    step("lui.F", 3'd0, 5'b01100);
    step("lui.D", 3'd1, 5'b00000);
    check("lui.E.alu", 32'(alu_op), 32'd3);
    check("lui.E.srcb", 32'(alu_src_b), 32'd1);
    check("lui.E.ext", 32'(ext_op), 32'd0);
    step("lui.E", 3'd2, 5'b00000);
    step("lui.W", 3'd4, 5'b00010);
    check("lui.ret", 32'(retired), 32'd4);

    // lw: 5 cycles
    load(6'b100011, 6'b000000);
    step("lw.F", 3'd0, 5'b01100);
    step("lw.D", 3'd1, 5'b00000);
    check("lw.E.alu", 32'(alu_op), 32'd0);
    check("lw.E.srcb", 32'(alu_src_b), 32'd1);
    check("lw.E.ext", 32'(ext_op), 32'd1);
    step("lw.E", 3'd2, 5'b00000);
    check("lw.M.ctl", 32'({alu_op, alu_src_b, ext_op}), 32'b00011);
    step("lw.M", 3'd3, 5'b00000);
    check("lw.W.ctl", 32'({alu_op, alu_src_b, ext_op}), 32'b00011);
    check("lw.W.wd", 32'(rf_wd_sel), 32'd1);
    check("lw.W.wa", 32'(rf_wa_sel), 32'd0);
    step("lw.W", 3'd4, 5'b00010);

    // sw: 4 cycles, dm_we only in MEM
    load(6'b101011, 6'b000000);
    step("sw.F", 3'd0, 5'b01100);
    step("sw.D", 3'd1, 5'b00000);
    check("sw.E.srcb", 32'(alu_src_b), 32'd1);
    step("sw.E", 3'd2, 5'b00000);
    step("sw.M", 3'd3, 5'b00001);
    check("sw.end.state", 32'(state), 32'd0);
    check("sw.ret", 32'(retired), 32'd6);

    // beq not taken, then taken
    load(6'b000100, 6'b000000);
    zero = 1'b0;
    step("beq0.F", 3'd0, 5'b01100);
    step("beq0.D", 3'd1, 5'b00000);
    check("beq0.E.npc", 32'(npc_sel), 32'd1);
    check("beq0.E.alu", 32'(alu_op), 32'd1);
    check("beq0.E.srcb", 32'(alu_src_b), 32'd0);
    step("beq0.E", 3'd2, 5'b00000);
    zero = 1'b1;
    #1;
    step("beq1.F", 3'd0, 5'b01100);
    step("beq1.D", 3'd1, 5'b00000);
    check("beq1.E.npc", 32'(npc_sel), 32'd1);
    step("beq1.E", 3'd2, 5'b01000);
    zero = 1'b0;
    check("beq.ret", 32'(retired), 32'd8);

    // undecoded opcode: one-cycle illegal, no writes, not retired
    load(6'b111111, 6'b000000);
    step("ill.F", 3'd0, 5'b01100);
    step("ill.D", 3'd1, 5'b10000);
    check("ill.next.state", 32'(state), 32'd0);
    check("ill.next.illegal", 32'(illegal), 32'd0);
    check("ill.ret", 32'(retired), 32'd8);

    // jr
    load(6'b000000, 6'b001000);
    step("jr.F", 3'd0, 5'b01100);
    check("jr.D.npc", 32'(npc_sel), 32'd3);
    step("jr.D", 3'd1, 5'b01000);
    check("jr.ret", 32'(retired), 32'd9);

    // jal depends on build configuration
    load(6'b000011, 6'b000000);
    step("jal.F", 3'd0, 5'b01100);
`ifdef MC_CTRL_JAL_EN
    check("jal.D.npc", 32'(npc_sel), 32'd2);
    check("jal.D.wa", 32'(rf_wa_sel), 32'd2);
    check("jal.D.wd", 32'(rf_wd_sel), 32'd2);
    step("jal.D", 3'd1, 5'b01010);
    check("jal.ret", 32'(retired), 32'd10);
`else
    step("jal.D", 3'd1, 5'b10000);
    check("jal.ret", 32'(retired), 32'd9);
`endif

    // reset during lw MEM aborts the instruction
    load(6'b100011, 6'b000000);
    step("lwr.F", 3'd0, 5'b01100);
    step("lwr.D", 3'd1, 5'b00000);
    step("lwr.E", 3'd2, 5'b00000);
    check("lwr.M.state", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    check("lwr.M.we", 32'(wev()), 32'd0);
    cyc();
    check("lwr.rst.state", 32'(state), 32'd0);
    check("lwr.rst.ret", 32'(retired), 32'd0);
    check("lwr.rst.we", 32'(wev()), 32'd0);
    reset = 1'b0;
    #1;

    // 16 j instructions wrap the 4-bit counter
    load(6'b000010, 6'b000000);
    for (int i = 0; i < 16; i++) begin
      step("j.F", 3'd0, 5'b01100);
      check("j.D.npc", 32'(npc_sel), 32'd2);
      step("j.D", 3'd1, 5'b01000);
      if (i == 14) check("j.ret15", 32'(retired), 32'd15);
    end
    check("j.wrap", 32'(retired), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
